// File: rtl/ga_mem_pkg.sv
// rtl/ga_mem_pkg.sv - phase constants, sequencer state enum and window helper
package ga_mem_pkg;

    // One frame is 16 clks: video slot in phases 0-7, CPU slot in phases 8-15.
    localparam logic [3:0] PH_VID_FIRST       = 4'd0;
    localparam logic [3:0] PH_VID_LAST        = 4'd7;
    localparam logic [3:0] PH_CPU_FIRST       = 4'd8;
    localparam logic [3:0] PH_CPU_LAST        = 4'd15;

    // CPU slot DRAM timing.
    localparam logic [3:0] PH_ACC_RAS_FIRST   = 4'd9;
    localparam logic [3:0] PH_ACC_RAS_LAST    = 4'd14;
    localparam logic [3:0] PH_ACC_CAS_FIRST   = 4'd11;
    localparam logic [3:0] PH_ACC_CAS_LAST    = 4'd14;
    localparam logic [3:0] PH_ACC_RAMRD_FIRST = 4'd9;

    // Video slot is two 4-clk byte fetches; these are sub-phases within a fetch.
    localparam logic [1:0] VID_RAS_SUB        = 2'd1;
    localparam logic [1:0] VID_CAS_SUB        = 2'd2;
    localparam logic [1:0] VID_STROBE_SUB     = 2'd3;
    localparam logic [1:0] CPU_CE_SUB         = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } seq_state_t;

    function automatic logic in_window(input logic [3:0] p,
                                       input logic [3:0] lo,
                                       input logic [3:0] hi);
        return (p >= lo) && (p <= hi);
    endfunction

endpackage

// File: rtl/ga_phase_counter.sv
// rtl/ga_phase_counter.sv - 16-phase frame counter with CPU enable and video decode
//
// Ports:
//   clk, reset   : system clock, synchronous active-high reset
//   phase        : registered frame phase 0..15
//   phase_next   : phase value entered on the next clk (wraps 15 -> 0)
//   cpu_ce       : one-clk pulse at phases 3, 7, 11, 15
//   vid_byte     : video byte select, 0 in phases 0-3, 1 in phases 4-7
//   vid_strobe   : one-clk pulse at phases 3 and 7
module ga_phase_counter
    import ga_mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] phase,
    output logic [3:0] phase_next,
    output logic       cpu_ce,
    output logic       vid_byte,
    output logic       vid_strobe
);

    logic in_video;

    assign phase_next = phase + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= PH_VID_FIRST;
        end else begin
            phase <= phase_next;
        end
    end

    assign in_video   = in_window(phase, PH_VID_FIRST, PH_VID_LAST);
    assign cpu_ce     = (phase[1:0] == CPU_CE_SUB);
    assign vid_byte   = in_video & phase[2];
    assign vid_strobe = in_video & (phase[1:0] == VID_STROBE_SUB);

endmodule

// File: rtl/ga_memory_sequencer.sv
// rtl/ga_memory_sequencer.sv - Z80/video DRAM slot sequencer with optional ROM overlay
//
// Optional feature macro: GA_ROM_MAP_EN (ROM overlay decode and romen_n).
//
// Ports:
//   clk, reset            : 16 MHz clock, synchronous active-high reset
//   mreq_n, rd_n, wr_n    : Z80 bus strobes, active low
//   cpu_a15_14            : CPU address bits 15:14
//   lrom_dis, urom_dis    : lower/upper ROM disable, active high
//   ras_n, cas_n, mwe_n   : DRAM strobes, active low
//   cpu_n                 : 0 = CPU address to RAM, 1 = video address
//   ready                 : 0 = Z80 wait; 1 also opens the RAM data latch
//   romen_n, ramrd_n      : ROM/RAM read enables to CPU data mux, active low
//   vid_byte, vid_strobe  : video byte select / byte-valid pulse
//   cpu_ce                : 4 MHz CPU clock enable pulse
//
// The FSM decides transitions against phase_next, so the state register and
// the phase register always describe the same clk: a request sampled on the
// edge that enters phase 8 goes straight to ACCESS, and every output is a
// decode of registered phase/state only.
module ga_memory_sequencer
    import ga_mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       mreq_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic [1:0] cpu_a15_14,
    input  logic       lrom_dis,
    input  logic       urom_dis,
    output logic       ras_n,
    output logic       cas_n,
    output logic       mwe_n,
    output logic       cpu_n,
    output logic       ready,
    output logic       romen_n,
    output logic       ramrd_n,
    output logic       vid_byte,
    output logic       vid_strobe,
    output logic       cpu_ce
);

`ifdef GA_ROM_MAP_EN
    localparam logic ROM_MAP_EN = 1'b1;
`else
    localparam logic ROM_MAP_EN = 1'b0;
`endif

    logic [3:0] phase;
    logic [3:0] phase_next;
    seq_state_t state, state_next;
    logic       acc_wr, acc_rom;
    logic       latch_acc;
    logic       request;
    logic       rom_decode;
    logic       rom_mapped;
    logic       in_video;
    logic [1:0] sub;

    ga_phase_counter u_phase (
        .clk        (clk),
        .reset      (reset),
        .phase      (phase),
        .phase_next (phase_next),
        .cpu_ce     (cpu_ce),
        .vid_byte   (vid_byte),
        .vid_strobe (vid_strobe)
    );

    assign request    = ~mreq_n & (~rd_n | ~wr_n);
    assign rom_decode = ((cpu_a15_14 == 2'b00) & ~lrom_dis) |
                        ((cpu_a15_14 == 2'b11) & ~urom_dis);
    assign rom_mapped = ROM_MAP_EN & rom_decode;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            acc_wr  <= 1'b0;
            acc_rom <= 1'b0;
        end else begin
            state <= state_next;
            if (latch_acc) begin
                acc_wr  <= ~wr_n;
                // Writes always land in RAM, so only reads can target ROM.
                acc_rom <= ~rd_n & wr_n & rom_mapped;
            end
        end
    end

    always_comb begin
        state_next = state;
        latch_acc  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (request) begin
                    if (phase_next == PH_CPU_FIRST) begin
                        state_next = ST_ACCESS;
                        latch_acc  = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (mreq_n) begin
                    state_next = ST_IDLE;
                end else if (phase_next == PH_CPU_FIRST) begin
                    state_next = ST_ACCESS;
                    latch_acc  = 1'b1;
                end
            end
            ST_ACCESS: begin
                // mreq_n is ignored here: a started slot always runs to the end.
                if (phase == PH_CPU_LAST) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // Hold off until the bus cycle ends so it gets exactly one slot.
                if (mreq_n) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign in_video = in_window(phase, PH_VID_FIRST, PH_VID_LAST);
    assign sub      = phase[1:0];
    assign cpu_n    = in_video;
    assign ready    = (state != ST_WAIT);

    always_comb begin
        ras_n   = 1'b1;
        cas_n   = 1'b1;
        mwe_n   = 1'b1;
        romen_n = 1'b1;
        ramrd_n = 1'b1;
        if (in_video) begin
            ras_n = ~(sub >= VID_RAS_SUB);
            cas_n = ~(sub >= VID_CAS_SUB);
        end else if (state == ST_ACCESS) begin
            if (acc_rom) begin
                // ACCESS covers the whole CPU slot, so ROM enable spans 8-15.
                romen_n = ~ROM_MAP_EN;
            end else begin
                ras_n   = ~in_window(phase, PH_ACC_RAS_FIRST, PH_ACC_RAS_LAST);
                cas_n   = ~in_window(phase, PH_ACC_CAS_FIRST, PH_ACC_CAS_LAST);
                mwe_n   = ~(acc_wr & in_window(phase, PH_ACC_CAS_FIRST, PH_ACC_CAS_LAST));
                ramrd_n = ~(~acc_wr & (phase >= PH_ACC_RAMRD_FIRST));
            end
        end
    end

endmodule

// File: tb/tb_ga_memory_sequencer.sv
// tb/tb_ga_memory_sequencer.sv - self-checking bench for ga_memory_sequencer
`timescale 1ns/1ps
module tb_ga_memory_sequencer;

`ifdef GA_ROM_MAP_EN
    localparam bit ROM_MAP_EN = 1'b1;
`else
    localparam bit ROM_MAP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mreq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
    logic [1:0] cpu_a15_14 = 2'b01;
    logic       lrom_dis = 1'b0, urom_dis = 1'b0;
    logic       ras_n, cas_n, mwe_n, cpu_n, ready, romen_n, ramrd_n;
    logic       vid_byte, vid_strobe, cpu_ce;

    always #31 clk = ~clk;

    ga_memory_sequencer dut (
        .clk(clk), .reset(reset), .mreq_n(mreq_n), .rd_n(rd_n), .wr_n(wr_n),
        .cpu_a15_14(cpu_a15_14), .lrom_dis(lrom_dis), .urom_dis(urom_dis),
        .ras_n(ras_n), .cas_n(cas_n), .mwe_n(mwe_n), .cpu_n(cpu_n), .ready(ready),
        .romen_n(romen_n), .ramrd_n(ramrd_n), .vid_byte(vid_byte),
        .vid_strobe(vid_strobe), .cpu_ce(cpu_ce)
    );

    int n_asserts = 0;
    int n_fail = 0;

    // Reference model: frame position, whether the bus cycle is waiting for
    // its slot, owns the current CPU slot, or has already been served.
    int m_ph = 0;
    bit m_wait = 0, m_slot = 0, m_done = 0, m_wr = 0, m_rom = 0;

    int c_ready_lo, c_ras_cpu, c_cas_cpu, c_mwe_lo, c_romen_lo, c_ramrd_lo;
    int c_strobe, c_ce, c_ras_vid;

    function automatic bit rom_hit(input logic [1:0] a, input logic l, input logic u);
        return ROM_MAP_EN && ((a == 2'b00 && !l) || (a == 2'b11 && !u));
    endfunction

    task automatic model_edge();
        bit req;
        int nph;
        req = !mreq_n && (!rd_n || !wr_n);
        if (reset) begin
            m_ph = 0; m_wait = 0; m_slot = 0; m_done = 0; m_wr = 0; m_rom = 0;
            return;
        end
        nph = (m_ph + 1) % 16;
        if (m_slot) begin
            if (nph == 0) begin m_slot = 0; m_done = 1; end
        end else if (m_done) begin
            if (mreq_n) m_done = 0;
        end else if (m_wait && mreq_n) begin
            m_wait = 0;
        end else if (m_wait || req) begin
            if (nph == 8) begin
                m_slot = 1; m_wait = 0;
                m_wr = !wr_n;
                m_rom = !rd_n && wr_n && rom_hit(cpu_a15_14, lrom_dis, urom_dis);
            end else begin
                m_wait = 1;
            end
        end
        m_ph = nph;
    endtask

    // {ras_n,cas_n,mwe_n,cpu_n,ready,romen_n,ramrd_n,vid_byte,vid_strobe,cpu_ce}
    function automatic logic [9:0] expected();
        logic ras, cas, mwe, romen, ramrd;
        ras = 1; cas = 1; mwe = 1; romen = 1; ramrd = 1;
        if (m_ph < 8) begin
            ras = !(m_ph inside {[1:3], [5:7]});
            cas = !(m_ph inside {2, 3, 6, 7});
        end else if (m_slot) begin
            if (m_rom) begin
                romen = 0;
            end else begin
                ras   = !(m_ph inside {[9:14]});
                cas   = !(m_ph inside {[11:14]});
                mwe   = !(m_wr && (m_ph inside {[11:14]}));
                ramrd = !(!m_wr && (m_ph inside {[9:15]}));
            end
        end
        return {ras, cas, mwe, (m_ph < 8), !m_wait, romen, ramrd,
                (m_ph inside {[4:7]}), (m_ph inside {3, 7}), (m_ph inside {3, 7, 11, 15})};
    endfunction

    task automatic check_outputs();
        logic [9:0] obs, exp;
        obs = {ras_n, cas_n, mwe_n, cpu_n, ready, romen_n, ramrd_n, vid_byte, vid_strobe, cpu_ce};
        exp = expected();
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL outputs ph=%0d observed=%b expected=%b", m_ph, obs, exp);
        end
        if (!ready) c_ready_lo++;
        if (!ras_n && m_ph >= 8) c_ras_cpu++;
        if (!ras_n && m_ph < 8) c_ras_vid++;
        if (!cas_n && m_ph >= 8) c_cas_cpu++;
        if (!mwe_n) c_mwe_lo++;
        if (!romen_n) c_romen_lo++;
        if (!ramrd_n) c_ramrd_lo++;
        if (vid_strobe) c_strobe++;
        if (cpu_ce) c_ce++;
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        c_ready_lo = 0; c_ras_cpu = 0; c_cas_cpu = 0; c_mwe_lo = 0; c_romen_lo = 0;
        c_ramrd_lo = 0; c_strobe = 0; c_ce = 0; c_ras_vid = 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    // Advance until the model sits in phase p; inputs set next are sampled
    // on the edge that enters phase p+1.
    task automatic go_to(input int p);
        for (int i = 0; i < 17 && m_ph != p; i++) step();
    endtask

    task automatic release_bus();
        mreq_n = 1; rd_n = 1; wr_n = 1;
    endtask

    initial begin
        int hold, idle;
        bit abort;
        clear_counts();

        // Reset state
        repeat (3) step();
        n_asserts++;
        assert ({ras_n, cas_n, mwe_n, cpu_n, ready, romen_n, ramrd_n, vid_byte, vid_strobe, cpu_ce}
                === 10'b1111111000) else begin
            n_fail++;
            $error("FAIL reset_outputs observed=%b expected=%b",
                   {ras_n, cas_n, mwe_n, cpu_n, ready, romen_n, ramrd_n, vid_byte, vid_strobe, cpu_ce},
                   10'b1111111000);
        end

        // Idle frames
        reset = 0;
        clear_counts();
        repeat (32) step();
        check_int("idle_vid_strobe", c_strobe, 4);
        check_int("idle_cpu_ce", c_ce, 8);
        check_int("idle_video_ras", c_ras_vid, 12);
        check_int("idle_cpu_ras", c_ras_cpu, 0);

        // RAM read detected at phase 2
        go_to(1);
        cpu_a15_14 = 2'b01; mreq_n = 0; rd_n = 0;
        clear_counts();
        repeat (15) step();
        check_int("rd_ready_low", c_ready_lo, 6);
        check_int("rd_ramrd_low", c_ramrd_lo, 7);
        check_int("rd_cas_low", c_cas_cpu, 4);
        release_bus();
        repeat (2) step();

        // Write at phase 8 to a ROM-mapped upper address
        go_to(7);
        cpu_a15_14 = 2'b11; urom_dis = 0; mreq_n = 0; wr_n = 0;
        clear_counts();
        repeat (9) step();
        check_int("wr_mwe_low", c_mwe_lo, 4);
        check_int("wr_romen_low", c_romen_lo, 0);
        check_int("wr_ready_low", c_ready_lo, 0);
        release_bus();
        repeat (2) step();

        // Read at phase 8 from lower ROM
        go_to(7);
        cpu_a15_14 = 2'b00; lrom_dis = 0; mreq_n = 0; rd_n = 0;
        clear_counts();
        repeat (9) step();
        if (ROM_MAP_EN) begin
            check_int("rom_romen_low", c_romen_lo, 8);
            check_int("rom_ras_low", c_ras_cpu, 0);
        end else begin
            check_int("rom_ramrd_low", c_ramrd_lo, 7);
            check_int("rom_romen_low", c_romen_lo, 0);
        end
        release_bus();
        repeat (2) step();

        // Request held for 3 frames gets one slot
        go_to(1);
        cpu_a15_14 = 2'b01; mreq_n = 0; rd_n = 0;
        clear_counts();
        repeat (48) step();
        check_int("held_one_access_ras", c_ras_cpu, 6);
        release_bus();
        repeat (2) step();

        // Request withdrawn while waiting
        go_to(2);
        mreq_n = 0; wr_n = 0;
        clear_counts();
        repeat (2) step();
        release_bus();
        repeat (20) step();
        check_int("abort_no_access", c_mwe_lo + c_ras_cpu, 0);

        // Reset pulsed during phase 12 of an access
        go_to(1);
        cpu_a15_14 = 2'b10; mreq_n = 0; rd_n = 0;
        for (int i = 0; i < 20 && !(m_slot && m_ph == 12); i++) step();
        check_int("reached_access_ph12", int'(m_slot && m_ph == 12), 1);
        reset = 1;
        step();
        check_int("reset_strobes_high",
                  int'({ras_n, cas_n, mwe_n, romen_n, ramrd_n}), 31);
        release_bus();
        reset = 0;
        repeat (3) step();

        // Randomized bus cycles against the model
        for (int t = 0; t < 40; t++) begin
            idle = $urandom_range(0, 20);
            repeat (idle) step();
            cpu_a15_14 = 2'($urandom_range(0, 3));
            lrom_dis = 1'($urandom_range(0, 1));
            urom_dis = 1'($urandom_range(0, 1));
            mreq_n = 0;
            if ($urandom_range(0, 1) == 1) rd_n = 0; else wr_n = 0;
            abort = ($urandom_range(0, 4) == 0);
            if (abort) begin
                hold = $urandom_range(1, 6);
                repeat (hold) step();
            end else begin
                for (int i = 0; i < 40 && !m_done; i++) step();
                check_int("rand_served", int'(m_done), 1);
                hold = $urandom_range(0, 3);
                repeat (hold) step();
            end
            release_bus();
            step();
        end
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/ga_memory_sequencer.md
GA_MEMORY_SEQUENCER -- requirements
Module: ga_memory_sequencer

Interface
REQ-001 SHALL have port `clk`, input, 1 bit: 16 MHz system clock; the only clock.
REQ-002 SHALL have port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have inputs `mreq_n`, `rd_n` and `wr_n`, 1 bit each: Z80 bus strobes, active low.
REQ-004 SHALL have input `cpu_a15_14`, 2 bits: CPU address bits 15:14.
REQ-005 SHALL have inputs `lrom_dis` and `urom_dis`, 1 bit each: lower/upper ROM disable from the GA mode register, active high.
REQ-006 SHALL have outputs `ras_n`, `cas_n` and `mwe_n`, 1 bit each: DRAM strobes, active low.
REQ-007 SHALL have output `cpu_n`, 1 bit: 0 selects CPU address to RAM, 1 selects video address.
REQ-008 SHALL have output `ready`, 1 bit: 0 inserts a Z80 wait; 1 also opens the RAM data latch.
REQ-009 SHALL have outputs `romen_n` and `ramrd_n`, 1 bit each: ROM/RAM read enables to the CPU data mux, active low.
REQ-010 SHALL have outputs `vid_byte` (1 bit: video byte select, 0/1) and `vid_strobe` (1 bit: one-clk pulse, video byte valid).
REQ-011 SHALL have output `cpu_ce`, 1 bit: one-clk pulse every 4 clks (4 MHz CPU enable).

Function
REQ-012 SHALL run a 4-bit phase counter 0..15 that increments every clk and wraps 15->0 (1 us frame).
REQ-013 SHALL assert `cpu_ce` at phases 3, 7, 11 and 15.
REQ-014 Video slot, phases 0-7: `cpu_n`=1; `vid_byte`=0 in phases 0-3 and 1 in phases 4-7.
REQ-015 Video slot: `ras_n`=0 in phases 1-3 and 5-7; `cas_n`=0 in phases 2-3 and 6-7; `mwe_n`=1 throughout.
REQ-016 SHALL pulse `vid_strobe` at phases 3 and 7.
REQ-017 CPU slot, phases 8-15: `cpu_n`=0.
REQ-018 Request = `mreq_n`=0 AND (`rd_n`=0 OR `wr_n`=0).
REQ-019 FSM states: IDLE, WAIT, ACCESS, DONE.
REQ-020 IDLE: a request with phase != 8 -> WAIT; a request with phase == 8 -> ACCESS.
REQ-021 WAIT -> ACCESS at phase 8.
REQ-022 ACCESS lasts phases 8-15, then -> DONE.
REQ-023 DONE -> IDLE when `mreq_n`=1, so one bus cycle gets exactly one access.
REQ-024 `ready`=0 only in WAIT (including the IDLE clk that detects the request); 1 in every other state.
REQ-025 On entry to ACCESS, the sequencer SHALL latch `acc_wr`=~`wr_n` and `acc_rom`=(read AND ROM-mapped); these hold for the slot.
REQ-026 ROM-mapped = (`cpu_a15_14`==00 AND !`lrom_dis`) OR (`cpu_a15_14`==11 AND !`urom_dis`).
REQ-027 ACCESS with RAM target: `ras_n`=0 in phases 9-14; `cas_n`=0 in phases 11-14; `mwe_n`=0 in phases 11-14 only if `acc_wr`.
REQ-028 Writes SHALL always go to RAM, even when the address is ROM-mapped.
REQ-029 ACCESS read: `romen_n`=0 in phases 8-15 if `acc_rom`, otherwise `ramrd_n`=0 in phases 9-15; never both.
REQ-030 ACCESS ROM read: no RAS/CAS.
REQ-031 If `mreq_n` rises during WAIT, the FSM SHALL return to IDLE with no access.
REQ-032 If `mreq_n` rises during ACCESS, the slot SHALL complete unchanged.
REQ-033 All outputs SHALL be registered or decoded from registered state only.

Reset
REQ-034 While `reset`=1: phase=0, state=IDLE.
REQ-035 While `reset`=1: `ras_n`, `cas_n`, `mwe_n`, `romen_n`, `ramrd_n` and `cpu_n` = 1.
REQ-036 While `reset`=1: `ready`=1; `vid_byte`, `vid_strobe` and `cpu_ce` = 0.
REQ-037 Reset mid-ACCESS SHALL deassert all strobes on the next clk.

Configuration
REQ-038 Macro `GA_ROM_MAP_EN`, when defined: ROM decode per REQ-026 and REQ-029.
REQ-039 When `GA_ROM_MAP_EN` is undefined: `romen_n` is tied to 1, `acc_rom` is always 0, and all reads are RAM reads.

Structure
REQ-040 Package `ga_mem_pkg` SHALL hold the phase constants (video/CPU slot bounds, RAS/CAS phases) and the FSM state enum.
REQ-041 Sub-module `ga_phase_counter` (counter plus `cpu_ce`, `vid_byte`, `vid_strobe` decode) SHALL be instantiated once.

Verification
REQ-042 Reset released, no requests, 32 clks -> `ras_n` low at phases 1-3 and 5-7; `vid_strobe` at phases 3, 7, 19 and 23; `cpu_ce` every 4 clks.
REQ-043 Read at phase 2, `cpu_a15_14`=01 -> `ready`=0 for phases 2-7; at phase 8 `ready`=1; `ramrd_n`=0 phases 9-15; `cas_n`=0 phases 11-14.
REQ-044 Write at phase 8, `cpu_a15_14`=11, `urom_dis`=0 -> `mwe_n`=0 phases 11-14; `romen_n` stays 1.
REQ-045 Read at phase 8, `cpu_a15_14`=00, `lrom_dis`=0 -> `romen_n`=0 phases 8-15; no RAS; with `GA_ROM_MAP_EN` undefined -> `ramrd_n`=0 instead.
REQ-046 Request held for 3 frames -> exactly one ACCESS; `reset` pulsed at phase 12 of an ACCESS -> all strobes high on the next clk.
